// File: rtl/shift_seq_pkg.sv
// rtl/shift_seq_pkg.sv - shared op, command-kind and state encodings for the shift command sequencer
package shift_seq_pkg;

  // alu op encoding, shared by the command port and the alu
  localparam logic [1:0] OP_SHL = 2'b00;
  localparam logic [1:0] OP_SHR = 2'b01;
  localparam logic [1:0] OP_ROL = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  localparam logic KIND_LOAD = 1'b0;
  localparam logic KIND_EXEC = 1'b1;

  // largest shift the 4-bit alu shift input can take in one pass
  localparam int MAX_PASS_SH = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/shift_cmd_seq_alu.sv
// rtl/shift_cmd_seq_alu.sv - combinational 16-bit shift/rotate alu, one pass of 0..15
//   data_i  16  operand
//   shift_i 4   shift/rotate amount
//   op_i    2   SHL/SHR/ROL/ROR
//   data_o  16  result
module shift_cmd_seq_alu
  import shift_seq_pkg::*;
(
  input  logic [15:0] data_i,
  input  logic [3:0]  shift_i,
  input  logic [1:0]  op_i,
  output logic [15:0] data_o
);

  // rotates come out of a doubled operand: the upper half after a left
  // shift is ROL, the lower half after a right shift is ROR
  logic [31:0] dbl_l;
  logic [31:0] dbl_r;

  always_comb begin
    dbl_l  = {data_i, data_i} << shift_i;
    dbl_r  = {data_i, data_i} >> shift_i;
    data_o = data_i;
    case (op_i)
      OP_SHL:  data_o = data_i << shift_i;
      OP_SHR:  data_o = data_i >> shift_i;
      OP_ROL:  data_o = dbl_l[31:16];
      OP_ROR:  data_o = dbl_r[15:0];
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/shift_cmd_seq.sv
// rtl/shift_cmd_seq.sv - LOAD/EXEC command sequencer feeding the shift alu in passes of up to 15
//   clk, rst_n            clock, async active-low reset
//   cmd_valid/cmd_ready   command handshake (ready only in IDLE)
//   cmd_kind/rd/rs/op/amt/imm  command fields (LOAD: rf[rd]<=imm, EXEC: rf[rd]<=op(rf[rs],amt))
//   res_valid/res_ready   EXEC result handshake
//   res_data/res_rd       result and the register it was written to
module shift_cmd_seq
  import shift_seq_pkg::*;
#(
  parameter  int NREG  = 4,
  parameter  int AMT_W = 5,
  localparam int RW    = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_kind,
  input  logic [RW-1:0]    cmd_rd,
  input  logic [RW-1:0]    cmd_rs,
  input  logic [1:0]       cmd_op,
  input  logic [AMT_W-1:0] cmd_amt,
  input  logic [15:0]      cmd_imm,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      res_data,
  output logic [RW-1:0]    res_rd
);

  state_e           state_q, state_d;
  logic [15:0]      rf_q [NREG];
  logic [15:0]      work_q, work_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [1:0]       op_q, op_d;
  logic [RW-1:0]    rd_q, rd_d;
  logic [15:0]      res_data_q, res_data_d;
  logic [RW-1:0]    res_rd_q, res_rd_d;

  logic             rf_we;
  logic [RW-1:0]    rf_waddr;
  logic [15:0]      rf_wdata;

  logic [3:0]       sh;
  logic [AMT_W-1:0] rem_left;
  logic [15:0]      alu_o;

  // clamp the remaining amount to what one alu pass can do
  assign sh       = (rem_q > AMT_W'(MAX_PASS_SH)) ? 4'(MAX_PASS_SH) : rem_q[3:0];
  assign rem_left = rem_q - AMT_W'(sh);

  shift_cmd_seq_alu u_alu (
    .data_i  (work_q),
    .shift_i (sh),
    .op_i    (op_q),
    .data_o  (alu_o)
  );

  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    rem_d      = rem_q;
    op_d       = op_q;
    rd_d       = rd_q;
    res_data_d = res_data_q;
    res_rd_d   = res_rd_q;
    rf_we      = 1'b0;
    rf_waddr   = cmd_rd;
    rf_wdata   = cmd_imm;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_kind == KIND_LOAD) begin
            rf_we = 1'b1;
          end else begin
            // source captured now, so rs == rd sees the pre-command value
            work_d  = rf_q[cmd_rs];
            rem_d   = cmd_amt;
            op_d    = cmd_op;
            rd_d    = cmd_rd;
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        work_d = alu_o;
        rem_d  = rem_left;
        if (rem_left == '0) begin
          rf_we      = 1'b1;
          rf_waddr   = rd_q;
          rf_wdata   = alu_o;
          res_data_d = alu_o;
          res_rd_d   = rd_q;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      work_q     <= '0;
      rem_q      <= '0;
      op_q       <= '0;
      rd_q       <= '0;
      res_data_q <= '0;
      res_rd_q   <= '0;
      for (int k = 0; k < NREG; k++) rf_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      rem_q      <= rem_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      res_data_q <= res_data_d;
      res_rd_q   <= res_rd_d;
      if (rf_we) rf_q[rf_waddr] <= rf_wdata;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign res_valid = (state_q == ST_RESP);
  assign res_data  = res_data_q;
  assign res_rd    = res_rd_q;

endmodule

// File: tb/tb_shift_cmd_seq.sv
// tb/tb_shift_cmd_seq.sv - directed and random self-checking bench for shift_cmd_seq
module tb_shift_cmd_seq;
  import shift_seq_pkg::*;

  localparam int NREG  = 4;
  localparam int AMT_W = 5;
  localparam int RW    = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_kind;
  logic [RW-1:0]    cmd_rd;
  logic [RW-1:0]    cmd_rs;
  logic [1:0]       cmd_op;
  logic [AMT_W-1:0] cmd_amt;
  logic [15:0]      cmd_imm;
  logic             res_valid;
  logic             res_ready;
  logic [15:0]      res_data;
  logic [RW-1:0]    res_rd;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] rf_m [NREG];

  shift_cmd_seq #(.NREG(NREG), .AMT_W(AMT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_kind  (cmd_kind),
    .cmd_rd    (cmd_rd),
    .cmd_rs    (cmd_rs),
    .cmd_op    (cmd_op),
    .cmd_amt   (cmd_amt),
    .cmd_imm   (cmd_imm),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_rd    (res_rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // whole-amount reference, independent of how passes are split
  function automatic logic [15:0] ref_op(input logic [15:0] v, input logic [1:0] op, input int amt);
    int r;
    logic [15:0] res;
    r = amt % 16;
    case (op)
      OP_SHL:  res = (amt >= 16) ? 16'h0 : (v << amt);
      OP_SHR:  res = (amt >= 16) ? 16'h0 : (v >> amt);
      OP_ROL:  res = (r == 0) ? v : ((v << r) | (v >> (16 - r)));
      default: res = (r == 0) ? v : ((v >> r) | (v << (16 - r)));
    endcase
    return res;
  endfunction

  function automatic int n_pass(input int amt);
    return (amt == 0) ? 1 : (amt + 14) / 15;
  endfunction

  task automatic clear_model();
    for (int k = 0; k < NREG; k++) rf_m[k] = 16'h0;
  endtask

  // drive a command and hold it until accepted; returns #1 after the accepting edge
  task automatic send(input logic kind, input int rd, input int rs, input logic [1:0] op,
                      input int amt, input logic [15:0] imm);
    int w;
    cmd_kind  = kind;
    cmd_rd    = RW'(rd);
    cmd_rs    = RW'(rs);
    cmd_op    = op;
    cmd_amt   = AMT_W'(amt);
    cmd_imm   = imm;
    cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 50) begin
      check("send_timeout", 32'd0, 32'd1);
    end else begin
      @(posedge clk); #1;
      if (kind == KIND_LOAD) rf_m[rd] = imm;
    end
    cmd_valid = 1'b0;
  endtask

  // EXEC with latency, data, rd and completion checks; hold = cycles res_ready stays low
  task automatic exec_chk(input string tag, input int rd, input int rs, input logic [1:0] op,
                          input int amt, input int hold);
    logic [15:0] exp;
    int cnt;
    exp = ref_op(rf_m[rs], op, amt);
    res_ready = (hold == 0);
    send(KIND_EXEC, rd, rs, op, amt, 16'h0);
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (!res_valid && cnt < 100);
    check({tag, "_lat"}, 32'(cnt), 32'(n_pass(amt)));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({tag, "_hold"}, {15'h0, res_valid, res_data}, {15'h0, 1'b1, exp});
    end
    check({tag, "_data"}, 32'(res_data), 32'(exp));
    check({tag, "_rd"}, 32'(res_rd), 32'(rd));
    res_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_done"}, 32'(res_valid), 32'd0);
    rf_m[rd] = exp;
  endtask

  initial begin
    int cnt;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_kind  = 1'b0;
    cmd_rd    = '0;
    cmd_rs    = '0;
    cmd_op    = '0;
    cmd_amt   = '0;
    cmd_imm   = '0;
    res_ready = 1'b1;
    clear_model();

    // reset with random inputs toggling
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      cmd_valid = 1'($urandom);
      cmd_kind  = 1'($urandom);
      cmd_rd    = RW'($urandom);
      cmd_rs    = RW'($urandom);
      cmd_op    = 2'($urandom);
      cmd_amt   = AMT_W'($urandom);
      cmd_imm   = 16'($urandom);
      res_ready = 1'($urandom);
    end
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_res_data", 32'(res_data), 32'd0);
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    exec_chk("rst_exec0", 0, 0, OP_SHL, 0, 0);

    send(KIND_LOAD, 1, 0, OP_SHL, 0, 16'h8001);
    exec_chk("rol1", 2, 1, OP_ROL, 1, 0);
    check("rol1_val", 32'(rf_m[2]), 32'h0003);
    exec_chk("read_r2", 3, 2, OP_SHL, 0, 0);

    send(KIND_LOAD, 0, 0, OP_SHL, 0, 16'hF00F);
    exec_chk("rol16", 1, 0, OP_ROL, 16, 0);
    exec_chk("shr16", 1, 0, OP_SHR, 16, 0);
    exec_chk("ror31", 3, 0, OP_ROR, 31, 0);
    check("ror31_val", 32'(rf_m[3]), 32'hE01F);
    exec_chk("rs_eq_rd", 3, 3, OP_ROL, 4, 2);

    // backpressure: result held, a LOAD offered meanwhile must not be taken
    res_ready = 1'b0;
    send(KIND_EXEC, 2, 0, OP_ROL, 4, 16'h0);
    cnt = 0;
    while (!res_valid && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("bp_valid", 32'(res_valid), 32'd1);
    cmd_kind  = KIND_LOAD;
    cmd_rd    = RW'(0);
    cmd_imm   = 16'h1234;
    cmd_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("bp_hold", {14'h0, res_valid, cmd_ready, res_data}, {14'h0, 1'b1, 1'b0, 16'h00FF});
      check("bp_rd", 32'(res_rd), 32'd2);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_idle", {30'h0, res_valid, cmd_ready}, {30'h0, 1'b0, 1'b1});
    cmd_valid = 1'b0;
    rf_m[2] = 16'h00FF;
    exec_chk("bp_r0_kept", 1, 0, OP_SHL, 0, 0);
    exec_chk("bp_r2", 1, 2, OP_SHL, 0, 0);

    // async reset during pass 2 of a 3-pass op
    send(KIND_EXEC, 3, 0, OP_ROR, 31, 16'h0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_async", {30'h0, res_valid, cmd_ready}, {30'h0, 1'b0, 1'b1});
    clear_model();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("mid_rst_no_res", 32'(res_valid), 32'd0);
    end
    exec_chk("mid_rst_r3", 3, 3, OP_SHL, 0, 0);
    exec_chk("mid_rst_r0", 0, 0, OP_ROL, 1, 0);

    // random traffic against the model
    for (int n = 0; n < 2000; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
      end
      if (($urandom % 2) == 0) begin
        send(KIND_LOAD, int'($urandom_range(0, NREG - 1)), 0, OP_SHL, 0, 16'($urandom));
      end else begin
        exec_chk("rnd", int'($urandom_range(0, NREG - 1)), int'($urandom_range(0, NREG - 1)),
                 2'($urandom), int'($urandom_range(0, 31)), int'($urandom_range(0, 3)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
